// File: rtl/flit_to_axis_deserializer.sv
// flit_to_axis_deserializer
// Receives credit-flow-controlled flits from a NoC router, buffers them in a
// small FIFO and reassembles every SERIALIZATION_FACTOR flits into one wide
// AXI-Stream beat. Single clock domain, asynchronous active-low reset.
// Flit 0 of a beat lands in the least significant bits of axis_tdata.

`timescale 1ns/1ps

module flit_to_axis_deserializer #(
  parameter int TDEST_WIDTH          = 6,
  parameter int TDATA_WIDTH          = 512,
  parameter int SERIALIZATION_FACTOR = 4,
  parameter int FLIT_BUFFER_DEPTH    = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [TDATA_WIDTH/SERIALIZATION_FACTOR-1:0]   data_in,
  input  logic [TDEST_WIDTH-1:0]                        dest_in,
  input  logic                                          is_tail_in,
  input  logic                                          send_in,
  output logic                                          credit_out,
  output logic                                          axis_tvalid,
  input  logic                                          axis_tready,
  output logic [TDATA_WIDTH-1:0]                        axis_tdata,
  output logic                                          axis_tlast,
  output logic [TDEST_WIDTH-1:0]                        axis_tdest,
  output logic                                          overflow_err
);

  localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
  localparam int PTR_W      = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int COUNT_W    = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int CNT_W      = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;

  localparam logic [PTR_W-1:0]   LAST_PTR   = PTR_W'(FLIT_BUFFER_DEPTH - 1);
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FLIT_BUFFER_DEPTH);
  localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(SERIALIZATION_FACTOR - 1);

  // Flit FIFO storage, one array per field
  logic [FLIT_WIDTH-1:0]  fifo_data [FLIT_BUFFER_DEPTH];
  logic [TDEST_WIDTH-1:0] fifo_dest [FLIT_BUFFER_DEPTH];
  logic                   fifo_tail [FLIT_BUFFER_DEPTH];

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [COUNT_W-1:0] fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  logic               do_write;
  logic               do_pop;
  logic               load_beat;

  logic [FLIT_WIDTH-1:0]  head_data;
  logic [TDEST_WIDTH-1:0] head_dest;
  logic                   head_tail;

  // Assembler state: flit position within the beat and the partial beat
  logic [CNT_W-1:0]       cnt;
  logic [TDATA_WIDTH-1:0] partial_data;
  logic [TDEST_WIDTH-1:0] partial_dest;

  logic [TDATA_WIDTH-1:0] beat_next;
  logic [TDEST_WIDTH-1:0] dest_next;

  // Full/empty come straight from the registered occupancy count
  assign fifo_full  = (fifo_count == FULL_COUNT);
  assign fifo_empty = (fifo_count == '0);

  // A flit arriving into a full FIFO is dropped, never written through
  assign do_write = send_in && !fifo_full;

  // The last flit of a beat may only pop when the output register can take it
  assign do_pop    = !fifo_empty && ((cnt != LAST_CNT) || !axis_tvalid || axis_tready);
  assign load_beat = do_pop && (cnt == LAST_CNT);

  assign head_data = fifo_data[rd_ptr];
  assign head_dest = fifo_dest[rd_ptr];
  assign head_tail = fifo_tail[rd_ptr];

  // FIFO payload write; storage needs no reset because occupancy gates reads
  always_ff @(posedge clk) begin
    if (do_write) begin
      fifo_data[wr_ptr] <= data_in;
      fifo_dest[wr_ptr] <= dest_in;
      fifo_tail[wr_ptr] <= is_tail_in;
    end
  end

  // FIFO pointers (wrap at depth, so any depth works) and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_write, do_pop})
        2'b10:   fifo_count <= fifo_count + COUNT_W'(1);
        2'b01:   fifo_count <= fifo_count - COUNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Merge the head flit into its slot of the partial beat; dest comes from flit 0
  always_comb begin
    beat_next = partial_data;
    for (int k = 0; k < SERIALIZATION_FACTOR; k++) begin
      if (cnt == CNT_W'(k)) begin
        beat_next[k*FLIT_WIDTH +: FLIT_WIDTH] = head_data;
      end
    end
    dest_next = (cnt == '0) ? head_dest : partial_dest;
  end

  // Assembler: advance the flit counter and keep the partial beat between pops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      partial_data <= '0;
      partial_dest <= '0;
    end else if (do_pop) begin
      if (load_beat) begin
        cnt <= '0;
      end else begin
        cnt          <= cnt + CNT_W'(1);
        partial_data <= beat_next;
        partial_dest <= dest_next;
      end
    end
  end

  // Output register: load a completed beat, hold it under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axis_tvalid <= 1'b0;
      axis_tdata  <= '0;
      axis_tlast  <= 1'b0;
      axis_tdest  <= '0;
    end else if (load_beat) begin
      axis_tvalid <= 1'b1;
      axis_tdata  <= beat_next;
      axis_tlast  <= head_tail;
      axis_tdest  <= dest_next;
    end else if (axis_tready) begin
      axis_tvalid <= 1'b0;
    end
  end

  // One credit back upstream for every flit that leaves the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_out <= 1'b0;
    end else begin
      credit_out <= do_pop;
    end
  end

  // Sticky error flag for flits that arrived while the FIFO was full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err <= 1'b0;
    end else if (send_in && fifo_full) begin
      overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_flit_to_axis_deserializer.sv
// tb_flit_to_axis_deserializer
// Scoreboard bench: expected beats are queued as their final flit is driven
// and compared when the DUT completes an AXI-Stream handshake.

`timescale 1ns/1ps

module tb_flit_to_axis_deserializer;

  localparam int TDEST_WIDTH = 6;
  localparam int TDATA_WIDTH = 512;
  localparam int SF          = 4;
  localparam int DEPTH       = 4;
  localparam int FW          = TDATA_WIDTH / SF;
  localparam int W           = TDATA_WIDTH;

  logic                   clk;
  logic                   rst_n;
  logic [FW-1:0]          data_in;
  logic [TDEST_WIDTH-1:0] dest_in;
  logic                   is_tail_in;
  logic                   send_in;
  logic                   credit_out;
  logic                   axis_tvalid;
  logic                   axis_tready;
  logic [TDATA_WIDTH-1:0] axis_tdata;
  logic                   axis_tlast;
  logic [TDEST_WIDTH-1:0] axis_tdest;
  logic                   overflow_err;

  flit_to_axis_deserializer #(
    .TDEST_WIDTH          (TDEST_WIDTH),
    .TDATA_WIDTH          (TDATA_WIDTH),
    .SERIALIZATION_FACTOR (SF),
    .FLIT_BUFFER_DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .dest_in      (dest_in),
    .is_tail_in   (is_tail_in),
    .send_in      (send_in),
    .credit_out   (credit_out),
    .axis_tvalid  (axis_tvalid),
    .axis_tready  (axis_tready),
    .axis_tdata   (axis_tdata),
    .axis_tlast   (axis_tlast),
    .axis_tdest   (axis_tdest),
    .overflow_err (overflow_err)
  );

  typedef struct {
    logic [TDATA_WIDTH-1:0] data;
    logic [TDEST_WIDTH-1:0] dest;
    logic                   last;
  } beat_t;

  beat_t exp_q[$];

  int total_checks  = 0;
  int bad_checks    = 0;
  int cycle_count   = 0;
  int hs_count      = 0;
  int last_hs_cycle = -1;
  int returned      = 0;
  int sent          = 0;
  bit streaming     = 1'b0;

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index used to measure handshake spacing
  always @(posedge clk) cycle_count++;

  task automatic check_output(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [FW-1:0] flit_data(input int b, input int k);
    return {32'(b), 32'(k), 32'hC0DE_0000 ^ 32'(b * 7), 24'(b), 8'hA0 + 8'(k)};
  endfunction

  function automatic logic [TDEST_WIDTH-1:0] flit_dest(input int b, input int k);
    return (k == 0) ? 6'(b * 5 + 3) : 6'(b * 11 + k + 1);
  endfunction

  function automatic logic flit_tail(input int b, input int k);
    return (k == SF - 1) ? b[0] : (k == 1);
  endfunction

  function automatic beat_t build_beat(input int b);
    beat_t e;
    e.data = '0;
    for (int k = 0; k < SF; k++) e.data[k*FW +: FW] = flit_data(b, k);
    e.dest = flit_dest(b, 0);
    e.last = flit_tail(b, SF - 1);
    return e;
  endfunction

  // Scoreboard and credit monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n && axis_tvalid && axis_tready) begin
      hs_count++;
      if (streaming && last_hs_cycle >= 0)
        check_output("stream gap", W'(cycle_count - last_hs_cycle), W'(SF));
      last_hs_cycle = cycle_count;
      check_output("beat expected", W'(exp_q.size() != 0), W'(1));
      if (exp_q.size() != 0) begin
        beat_t e;
        e = exp_q.pop_front();
        check_output("sb tdata", axis_tdata, e.data);
        check_output("sb tdest", W'(axis_tdest), W'(e.dest));
        check_output("sb tlast", W'(axis_tlast), W'(e.last));
      end
    end
    if (credit_out) returned++;
  end

  // Drive one flit of beat (base + sent/SF) when an upstream credit is available
  task automatic apply_stimulus(input int base, input int target);
    int b;
    int k;
    @(posedge clk);
    #1;
    if (sent < target && (DEPTH - sent + returned) > 0) begin
      b = base + sent / SF;
      k = sent % SF;
      send_in    = 1'b1;
      data_in    = flit_data(b, k);
      dest_in    = flit_dest(b, k);
      is_tail_in = flit_tail(b, k);
      if (k == SF - 1) exp_q.push_back(build_beat(b));
      sent++;
    end else begin
      send_in = 1'b0;
    end
  endtask

  // Asynchronous reset pulse asserted mid-cycle; optionally check outputs clear at once
  task automatic pulse_reset(input bit check_zero);
    @(posedge clk);
    #3;
    rst_n   = 1'b0;
    send_in = 1'b0;
    #1;
    if (check_zero) begin
      check_output("async tvalid", W'(axis_tvalid), W'(0));
      check_output("async tdata", axis_tdata, W'(0));
      check_output("async tlast", W'(axis_tlast), W'(0));
      check_output("async tdest", W'(axis_tdest), W'(0));
      check_output("async credit", W'(credit_out), W'(0));
      check_output("async overflow", W'(overflow_err), W'(0));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    returned = 0;
    sent     = 0;
  endtask

  task automatic wait_drain(input int bound);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < bound) begin
      @(negedge clk);
      i++;
    end
    check_output("drain", W'(exp_q.size()), W'(0));
  endtask

  task automatic check_no_credit(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check_output("idle credit", W'(credit_out), W'(0));
    end
  endtask

  initial begin
    int hs0;
    int sent_hold;
    int ret_hold;
    int first_drop;
    int i;

    rst_n       = 1'b0;
    send_in     = 1'b0;
    data_in     = '0;
    dest_in     = '0;
    is_tail_in  = 1'b0;
    axis_tready = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check_output("rst tvalid", W'(axis_tvalid), W'(0));
    check_output("rst tdata", axis_tdata, W'(0));
    check_output("rst tlast", W'(axis_tlast), W'(0));
    check_output("rst tdest", W'(axis_tdest), W'(0));
    check_output("rst credit", W'(credit_out), W'(0));
    check_output("rst overflow", W'(overflow_err), W'(0));
    rst_n = 1'b1;
    check_no_credit(4);

    // Single beat with exact latency of credits and tvalid
    $display("[TB] single beat");
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (c < SF) begin
        send_in    = 1'b1;
        data_in    = FW'(8'hA0 + 8'(c));
        dest_in    = 6'h2A;
        is_tail_in = (c == SF - 1);
        if (c == SF - 1) begin
          beat_t e;
          e.data = {128'hA3, 128'hA2, 128'hA1, 128'hA0};
          e.dest = 6'h2A;
          e.last = 1'b1;
          exp_q.push_back(e);
        end
      end else begin
        send_in    = 1'b0;
        is_tail_in = 1'b0;
      end
      @(negedge clk);
      check_output("single credit", W'(credit_out), W'(c >= 2 && c <= 5));
      if (c <= 4) check_output("single early tvalid", W'(axis_tvalid), W'(0));
      if (c == 5) begin
        check_output("single tvalid", W'(axis_tvalid), W'(1));
        check_output("single tdata", axis_tdata, {128'hA3, 128'hA2, 128'hA1, 128'hA0});
        check_output("single tlast", W'(axis_tlast), W'(1));
        check_output("single tdest", W'(axis_tdest), W'(6'h2A));
      end
    end
    @(posedge clk);
    #1;
    axis_tready = 1'b1;
    wait_drain(20);

    // Backpressure with an honest credit model
    $display("[TB] backpressure");
    pulse_reset(1'b0);
    axis_tready = 1'b0;
    for (int c = 0; c < 40; c++) begin
      apply_stimulus(100, 3 * SF);
      @(negedge clk);
      if (c == 20 || c == 39) begin
        check_output("bp tvalid", W'(axis_tvalid), W'(1));
        check_output("bp hold tdata", axis_tdata, exp_q[0].data);
        check_output("bp hold tdest", W'(axis_tdest), W'(exp_q[0].dest));
        check_output("bp hold tlast", W'(axis_tlast), W'(exp_q[0].last));
      end
    end
    sent_hold = sent;
    ret_hold  = returned;
    check_output("bp accepted", W'(sent_hold), W'(DEPTH + 2 * SF - 1));
    check_output("bp credits", W'(ret_hold), W'(2 * SF - 1));
    check_output("bp overflow", W'(overflow_err), W'(0));
    hs0 = hs_count;
    i = 0;
    while ((sent < 3 * SF || exp_q.size() != 0) && i < 60) begin
      apply_stimulus(100, 3 * SF);
      if (i == 0) axis_tready = 1'b1;
      @(negedge clk);
      i++;
    end
    check_output("bp sent all", W'(sent), W'(3 * SF));
    wait_drain(20);
    check_output("bp beats", W'(hs_count - hs0), W'(3));

    // Overflow: ignore credits with the output blocked
    $display("[TB] overflow");
    pulse_reset(1'b0);
    axis_tready = 1'b0;
    first_drop  = DEPTH + 2 * SF - 1;
    for (int n = 0; n < 3 * SF; n++) begin
      @(posedge clk);
      #1;
      send_in    = 1'b1;
      data_in    = flit_data(200 + n / SF, n % SF);
      dest_in    = flit_dest(200 + n / SF, n % SF);
      is_tail_in = flit_tail(200 + n / SF, n % SF);
      if (n % SF == SF - 1 && n < first_drop) exp_q.push_back(build_beat(200 + n / SF));
      @(negedge clk);
      check_output("ovf flag", W'(overflow_err), W'(n > first_drop));
    end
    @(posedge clk);
    #1;
    send_in = 1'b0;
    @(negedge clk);
    check_output("ovf set", W'(overflow_err), W'(1));
    check_output("ovf beat tdata", axis_tdata, exp_q[0].data);
    hs0 = hs_count;
    @(posedge clk);
    #1;
    axis_tready = 1'b1;
    wait_drain(30);
    repeat (5) @(negedge clk);
    check_output("ovf beats", W'(hs_count - hs0), W'(2));
    check_output("ovf sticky", W'(overflow_err), W'(1));

    // Reset mid-beat: outputs clear at once, stale flits vanish
    $display("[TB] reset mid-beat");
    pulse_reset(1'b1);
    check_no_credit(4);
    axis_tready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk);
      #1;
      send_in    = 1'b1;
      data_in    = flit_data(300, n);
      dest_in    = flit_dest(300, n);
      is_tail_in = flit_tail(300, n);
    end
    pulse_reset(1'b0);
    hs0 = hs_count;
    for (int n = 0; n < SF; n++) begin
      @(posedge clk);
      #1;
      send_in    = 1'b1;
      data_in    = flit_data(400, n);
      dest_in    = flit_dest(400, n);
      is_tail_in = flit_tail(400, n);
      if (n == SF - 1) exp_q.push_back(build_beat(400));
    end
    @(posedge clk);
    #1;
    send_in = 1'b0;
    wait_drain(20);
    repeat (8) @(negedge clk);
    check_output("mid-reset beats", W'(hs_count - hs0), W'(1));

    // Streaming: 100 beats, no bubbles
    $display("[TB] streaming");
    pulse_reset(1'b0);
    axis_tready   = 1'b1;
    last_hs_cycle = -1;
    streaming     = 1'b1;
    hs0 = hs_count;
    i = 0;
    while ((sent < 100 * SF || exp_q.size() != 0) && i < 2000) begin
      apply_stimulus(500, 100 * SF);
      @(negedge clk);
      i++;
    end
    streaming = 1'b0;
    check_output("stream sent", W'(sent), W'(100 * SF));
    wait_drain(20);
    check_output("stream beats", W'(hs_count - hs0), W'(100));
    check_output("stream overflow", W'(overflow_err), W'(0));

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
